// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, ALU select codes,
// FSM states, instruction field positions and the opcode class decoder.
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT, S_FAULT
   } state_e;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_ST   = 5'b00001;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_MUL = 4'd4;
   localparam logic [3:0] ALU_DIV = 4'd5;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   // Opcodes grouped by the shape of their execute sequence.
   typedef enum logic [3:0] {
      C_ALU3, C_MULDIV, C_LD, C_ST, C_MFHI,
      C_MFLO, C_NOP, C_HALT, C_ILL
   } cls_e;

   function automatic cls_e op_class(logic [4:0] op);
      cls_e c;
      case (op)
         OP_ADD, OP_SUB,
         OP_AND, OP_OR:   c = C_ALU3;
         OP_MUL, OP_DIV:  c = C_MULDIV;
         OP_LD:           c = C_LD;
         OP_ST:           c = C_ST;
         OP_MFHI:         c = C_MFHI;
         OP_MFLO:         c = C_MFLO;
         OP_NOP:          c = C_NOP;
         OP_HALT:         c = C_HALT;
         default:         c = C_ILL;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] alu_code(logic [4:0] op);
      logic [3:0] a;
      case (op)
         OP_SUB:  a = ALU_SUB;
         OP_AND:  a = ALU_AND;
         OP_OR:   a = ALU_OR;
         OP_MUL:  a = ALU_MUL;
         OP_DIV:  a = ALU_DIV;
         default: a = ALU_ADD;
      endcase
      return a;
   endfunction

   function automatic logic [15:0] onehot16(logic [3:0] idx);
      return 16'h0001 << idx;
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter with timeout compare.
// Ports: clock, clear (async low), wait_i (in a wait state),
// ready_i (memory done), timeout_o (limit reached while not ready).
module mem_wait_timer #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic clock,
   input  logic clear,
   input  logic wait_i,
   input  logic ready_i,
   output logic timeout_o
);

   localparam int CW = $clog2(MEM_WAIT_MAX + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit;

   // Counter sits at zero outside wait states, so every wait
   // state is entered with a fresh count.
   assign hit = wait_i && !ready_i &&
                (cnt_q == CW'(MEM_WAIT_MAX - 1));
   assign timeout_o = hit;

   always_comb begin
      cnt_d = '0;
      if (wait_i && !ready_i && !hit)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, opcode-driven execute T3-T6.
// Ports: clock, clear, run, ir, mem_ready in; register/datapath strobes,
// alu_select, halted/fault/busy and instr_count out.
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] ir,
   input  logic        mem_ready,
   output logic [15:0] r_in,
   output logic [15:0] r_out,
   output logic        pc_in,
   output logic        pc_out,
   output logic        inc_pc,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        mar_in,
   output logic        mdr_in,
   output logic        mdr_out,
   output logic        mdr_read,
   output logic        mem_write,
   output logic        hi_in,
   output logic        hi_out,
   output logic        lo_in,
   output logic        lo_out,
   output logic        zhigh_out,
   output logic        zlow_out,
   output logic [3:0]  alu_select,
   output logic        halted,
   output logic        fault,
   output logic        busy,
   output logic [15:0] instr_count
);

   state_e      state_q, state_d;
   logic [15:0] icnt_q, icnt_d;
   logic        seq_end, retire;
   logic        in_wait, timeout;
   logic [4:0]  op;
   logic [3:0]  ra, rb, rc;
   cls_e        cls;
   logic        unused_ir;

   assign op  = ir[OP_MSB:OP_LSB];
   assign ra  = ir[RA_MSB:RA_LSB];
   assign rb  = ir[RB_MSB:RB_LSB];
   assign rc  = ir[RC_MSB:RC_LSB];
   assign cls = op_class(op);
   assign unused_ir = ^ir[RC_LSB-1:0];

   assign in_wait = (state_q == S_T1) ||
                    (state_q == S_T4 && cls == C_LD) ||
                    (state_q == S_T5 && cls == C_ST);

   mem_wait_timer #(
      .MEM_WAIT_MAX (MEM_WAIT_MAX)
   ) u_wait (
      .clock     (clock),
      .clear     (clear),
      .wait_i    (in_wait),
      .ready_i   (mem_ready),
      .timeout_o (timeout)
   );

   always_comb begin
      state_d = state_q;
      seq_end = 1'b0;
      retire  = 1'b0;
      unique case (state_q)
         S_IDLE: if (run) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1: begin
            if (mem_ready)    state_d = S_T2;
            else if (timeout) state_d = S_FAULT;
         end
         S_T2:   state_d = S_T3;
         S_T3: begin
            case (cls)
               C_ALU3, C_MULDIV,
               C_LD, C_ST:       state_d = S_T4;
               C_MFHI, C_MFLO,
               C_NOP:            seq_end = 1'b1;
               C_HALT: begin
                  state_d = S_HALT;
                  retire  = 1'b1;
               end
               default:          state_d = S_FAULT;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU3, C_MULDIV,
               C_ST:             state_d = S_T5;
               C_LD: begin
                  if (mem_ready)    state_d = S_T5;
                  else if (timeout) state_d = S_FAULT;
               end
               default:          state_d = S_FAULT;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU3, C_LD:     seq_end = 1'b1;
               C_MULDIV:         state_d = S_T6;
               C_ST: begin
                  if (mem_ready)    seq_end = 1'b1;
                  else if (timeout) state_d = S_FAULT;
               end
               default:          state_d = S_FAULT;
            endcase
         end
         S_T6: begin
            if (cls == C_MULDIV) seq_end = 1'b1;
            else                 state_d = S_FAULT;
         end
         S_HALT, S_FAULT: ;
         default: state_d = S_FAULT;
      endcase
      if (seq_end) begin
         state_d = run ? S_T0 : S_IDLE;
         retire  = 1'b1;
      end
   end

   always_comb begin
      r_in       = '0;
      r_out      = '0;
      pc_in      = 1'b0;
      pc_out     = 1'b0;
      inc_pc     = 1'b0;
      ir_in      = 1'b0;
      y_in       = 1'b0;
      z_in       = 1'b0;
      mar_in     = 1'b0;
      mdr_in     = 1'b0;
      mdr_out    = 1'b0;
      mdr_read   = 1'b0;
      mem_write  = 1'b0;
      hi_in      = 1'b0;
      hi_out     = 1'b0;
      lo_in      = 1'b0;
      lo_out     = 1'b0;
      zhigh_out  = 1'b0;
      zlow_out   = 1'b0;
      alu_select = ALU_ADD;
      unique case (state_q)
         S_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         S_T1: begin
            zlow_out = 1'b1;
            pc_in    = 1'b1;
            mdr_read = 1'b1;
            mdr_in   = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         S_T3: begin
            case (cls)
               C_ALU3: begin
                  r_out = onehot16(rb);
                  y_in  = 1'b1;
               end
               C_MULDIV: begin
                  r_out = onehot16(ra);
                  y_in  = 1'b1;
               end
               C_LD, C_ST: begin
                  r_out  = onehot16(rb);
                  mar_in = 1'b1;
               end
               C_MFHI: begin
                  hi_out = 1'b1;
                  r_in   = onehot16(ra);
               end
               C_MFLO: begin
                  lo_out = 1'b1;
                  r_in   = onehot16(ra);
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               C_ALU3: begin
                  r_out      = onehot16(rc);
                  z_in       = 1'b1;
                  alu_select = alu_code(op);
               end
               C_MULDIV: begin
                  r_out      = onehot16(rb);
                  z_in       = 1'b1;
                  alu_select = alu_code(op);
               end
               C_LD: begin
                  mdr_read = 1'b1;
                  mdr_in   = 1'b1;
               end
               C_ST: begin
                  r_out  = onehot16(ra);
                  mdr_in = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               C_ALU3: begin
                  zlow_out = 1'b1;
                  r_in     = onehot16(ra);
               end
               C_MULDIV: begin
                  zlow_out = 1'b1;
                  lo_in    = 1'b1;
               end
               C_LD: begin
                  mdr_out = 1'b1;
                  r_in    = onehot16(ra);
               end
               C_ST:    mem_write = 1'b1;
               default: ;
            endcase
         end
         S_T6: begin
            if (cls == C_MULDIV) begin
               zhigh_out = 1'b1;
               hi_in     = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign halted      = (state_q == S_HALT);
   assign fault       = (state_q == S_FAULT);
   assign busy        = !(state_q == S_IDLE || halted || fault);
   assign instr_count = icnt_q;

   assign icnt_d = retire ? icnt_q + 16'd1 : icnt_q;

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         icnt_q  <= icnt_d;
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector tables of
// per-cycle inputs and expected outputs plus clear/timeout corner cases.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear = 1'b0;
   logic        run = 1'b0;
   logic        mem_ready = 1'b0;
   logic [31:0] ir = '0;
   logic [15:0] r_in, r_out, instr_count;
   logic        pc_in, pc_out, inc_pc, ir_in, y_in, z_in;
   logic        mar_in, mdr_in, mdr_out, mdr_read, mem_write;
   logic        hi_in, hi_out, lo_in, lo_out, zhigh_out, zlow_out;
   logic [3:0]  alu_select;
   logic        halted, fault, busy;

   control_sequencer #(.MEM_WAIT_MAX(15)) dut (
      .clock(clock), .clear(clear), .run(run), .ir(ir),
      .mem_ready(mem_ready), .r_in(r_in), .r_out(r_out),
      .pc_in(pc_in), .pc_out(pc_out), .inc_pc(inc_pc),
      .ir_in(ir_in), .y_in(y_in), .z_in(z_in), .mar_in(mar_in),
      .mdr_in(mdr_in), .mdr_out(mdr_out), .mdr_read(mdr_read),
      .mem_write(mem_write), .hi_in(hi_in), .hi_out(hi_out),
      .lo_in(lo_in), .lo_out(lo_out), .zhigh_out(zhigh_out),
      .zlow_out(zlow_out), .alu_select(alu_select),
      .halted(halted), .fault(fault), .busy(busy),
      .instr_count(instr_count)
   );

   always #5 clock = ~clock;

   localparam logic [16:0] PC_IN  = 17'h10000;
   localparam logic [16:0] PC_OUT = 17'h08000;
   localparam logic [16:0] INC_PC = 17'h04000;
   localparam logic [16:0] IR_IN  = 17'h02000;
   localparam logic [16:0] Y_IN   = 17'h01000;
   localparam logic [16:0] Z_IN   = 17'h00800;
   localparam logic [16:0] MAR_IN = 17'h00400;
   localparam logic [16:0] MDR_IN = 17'h00200;
   localparam logic [16:0] MDR_OT = 17'h00100;
   localparam logic [16:0] MDR_RD = 17'h00080;
   localparam logic [16:0] MEM_WR = 17'h00040;
   localparam logic [16:0] HI_IN  = 17'h00020;
   localparam logic [16:0] HI_OUT = 17'h00010;
   localparam logic [16:0] LO_IN  = 17'h00008;
   localparam logic [16:0] LO_OUT = 17'h00004;
   localparam logic [16:0] ZH_OUT = 17'h00002;
   localparam logic [16:0] ZL_OUT = 17'h00001;
   localparam logic [16:0] F0 = PC_OUT | MAR_IN | INC_PC | Z_IN;
   localparam logic [16:0] F1 = ZL_OUT | PC_IN | MDR_RD | MDR_IN;
   localparam logic [16:0] F2 = MDR_OT | IR_IN;
   localparam logic [2:0]  B = 3'b001;
   localparam logic [2:0]  F = 3'b010;
   localparam logic [2:0]  H = 3'b100;

   typedef struct {
      string       nm;
      logic        run;
      logic        mr;
      logic [31:0] ir;
      logic [16:0] stb;
      logic [15:0] rin;
      logic [15:0] rout;
      logic [3:0]  alu;
      logic [2:0]  st;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   n_chk = 0;
   int   n_fail = 0;

   function automatic logic [31:0] enc(logic [4:0] op, logic [3:0] ra,
                                       logic [3:0] rb, logic [3:0] rc);
      return {op, ra, rb, rc, 15'd0};
   endfunction

   function automatic logic [71:0] snap();
      return {pc_in, pc_out, inc_pc, ir_in, y_in, z_in, mar_in, mdr_in,
              mdr_out, mdr_read, mem_write, hi_in, hi_out, lo_in, lo_out,
              zhigh_out, zlow_out, r_in, r_out, alu_select,
              halted, fault, busy, instr_count};
   endfunction

   task automatic chk(string nm, logic [71:0] act, logic [71:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic push(string nm, logic r, logic m, logic [31:0] i,
                       logic [16:0] s, logic [15:0] ri, logic [15:0] ro,
                       logic [3:0] a, logic [2:0] st, logic [15:0] c);
      vec_t v;
      v.nm = nm; v.run = r; v.mr = m; v.ir = i; v.stb = s;
      v.rin = ri; v.rout = ro; v.alu = a; v.st = st; v.cnt = c;
      tbl.push_back(v);
   endtask

   task automatic fetch(string nm, logic [31:0] i, logic [15:0] c);
      push({nm, "_t0"}, 1, 1, i, F0, 0, 0, 0, B, c);
      push({nm, "_t1"}, 1, 1, i, F1, 0, 0, 0, B, c);
      push({nm, "_t2"}, 1, 1, i, F2, 0, 0, 0, B, c);
   endtask

   // Each vector: at the falling edge compare outputs, then drive inputs.
   task automatic run_tbl();
      foreach (tbl[k]) begin
         @(negedge clock);
         chk(tbl[k].nm, snap(),
             {tbl[k].stb, tbl[k].rin, tbl[k].rout, tbl[k].alu,
              tbl[k].st, tbl[k].cnt});
         run = tbl[k].run;
         mem_ready = tbl[k].mr;
         ir = tbl[k].ir;
      end
      tbl.delete();
   endtask

   // Called just after a falling edge: clear takes effect at once.
   task automatic do_clear(logic run_after);
      clear = 1'b0;
      run = 1'b0;
      #1;
      chk("clear_async", snap(), 72'd0);
      @(negedge clock);
      clear = 1'b1;
      run = run_after;
      mem_ready = 1'b1;
   endtask

   always @(negedge clock) begin : bus_mon
      int drv;
      drv = $countones(r_out) + int'(pc_out) + int'(mdr_out) +
            int'(hi_out) + int'(lo_out) + int'(zhigh_out) + int'(zlow_out);
      n_chk++;
      if (drv > 1) begin
         n_fail++;
         $display("FAIL bus_onehot: got %0d drivers required <=1", drv);
      end
   end

   logic [31:0] i_add, i_sub, i_mul, i_div, i_mfhi, i_mflo, i_or;
   logic [31:0] i_nop, i_st, i_halt, i_ld, i_ill;

   initial begin
      i_add  = enc(5'b00011, 3, 1, 2);
      i_sub  = enc(5'b00100, 7, 5, 9);
      i_mul  = enc(5'b01111, 4, 6, 0);
      i_div  = enc(5'b10000, 1, 2, 0);
      i_mfhi = enc(5'b11000, 2, 0, 0);
      i_mflo = enc(5'b11001, 10, 0, 0);
      i_or   = enc(5'b00110, 0, 15, 14);
      i_nop  = enc(5'b11010, 0, 0, 0);
      i_st   = enc(5'b00001, 9, 3, 0);
      i_halt = enc(5'b11011, 0, 0, 0);
      i_ld   = enc(5'b00000, 5, 2, 0);
      i_ill  = enc(5'b10101, 0, 0, 0);

      repeat (2) @(negedge clock);
      chk("reset", snap(), 72'd0);
      clear = 1'b1;

      push("idle", 1, 1, i_add, 0, 0, 0, 0, 0, 0);
      fetch("add", i_add, 0);
      push("add_t3", 1, 1, i_add, Y_IN, 0, 16'h0002, 0, B, 0);
      push("add_t4", 1, 1, i_add, Z_IN, 0, 16'h0004, 0, B, 0);
      push("add_t5", 1, 1, i_add, ZL_OUT, 16'h0008, 0, 0, B, 0);
      fetch("sub", i_sub, 1);
      push("sub_t3", 1, 1, i_sub, Y_IN, 0, 16'h0020, 0, B, 1);
      push("sub_t4", 1, 1, i_sub, Z_IN, 0, 16'h0200, 1, B, 1);
      push("sub_t5", 1, 1, i_sub, ZL_OUT, 16'h0080, 0, 0, B, 1);
      fetch("mul", i_mul, 2);
      push("mul_t3", 1, 1, i_mul, Y_IN, 0, 16'h0010, 0, B, 2);
      push("mul_t4", 1, 1, i_mul, Z_IN, 0, 16'h0040, 4, B, 2);
      push("mul_t5", 1, 1, i_mul, ZL_OUT | LO_IN, 0, 0, 0, B, 2);
      push("mul_t6", 1, 1, i_mul, ZH_OUT | HI_IN, 0, 0, 0, B, 2);
      fetch("div", i_div, 3);
      push("div_t3", 1, 1, i_div, Y_IN, 0, 16'h0002, 0, B, 3);
      push("div_t4", 1, 1, i_div, Z_IN, 0, 16'h0004, 5, B, 3);
      push("div_t5", 1, 1, i_div, ZL_OUT | LO_IN, 0, 0, 0, B, 3);
      push("div_t6", 1, 1, i_div, ZH_OUT | HI_IN, 0, 0, 0, B, 3);
      fetch("mfhi", i_mfhi, 4);
      push("mfhi_t3", 1, 1, i_mfhi, HI_OUT, 16'h0004, 0, 0, B, 4);
      fetch("mflo", i_mflo, 5);
      push("mflo_t3", 1, 1, i_mflo, LO_OUT, 16'h0400, 0, 0, B, 5);
      fetch("or", i_or, 6);
      push("or_t3", 1, 1, i_or, Y_IN, 0, 16'h8000, 0, B, 6);
      push("or_t4", 1, 1, i_or, Z_IN, 0, 16'h4000, 3, B, 6);
      push("or_t5", 0, 1, i_or, ZL_OUT, 16'h0001, 0, 0, B, 6);
      push("idle_a", 0, 1, i_nop, 0, 0, 0, 0, 0, 7);
      push("idle_b", 1, 1, i_nop, 0, 0, 0, 0, 0, 7);
      fetch("nop", i_nop, 7);
      push("nop_t3", 1, 1, i_nop, 0, 0, 0, 0, B, 7);
      fetch("st", i_st, 8);
      push("st_t3", 1, 1, i_st, MAR_IN, 0, 16'h0008, 0, B, 8);
      push("st_t4", 1, 1, i_st, MDR_IN, 0, 16'h0200, 0, B, 8);
      push("st_t5", 1, 1, i_st, MEM_WR, 0, 0, 0, B, 8);
      fetch("halt", i_halt, 9);
      push("halt_t3", 1, 1, i_halt, 0, 0, 0, 0, B, 9);
      push("halted_a", 1, 1, i_halt, 0, 0, 0, 0, H, 10);
      push("halted_b", 1, 1, i_halt, 0, 0, 0, 0, H, 10);
      run_tbl();

      do_clear(1'b0);
      push("ld_idle", 1, 1, i_ld, 0, 0, 0, 0, 0, 0);
      fetch("ld", i_ld, 0);
      push("ld_t3", 1, 0, i_ld, MAR_IN, 0, 16'h0004, 0, B, 0);
      for (int k = 0; k < 4; k++)
         push("ld_t4_wait", 0, (k == 3), i_ld,
              MDR_RD | MDR_IN, 0, 0, 0, B, 0);
      push("ld_t5", 0, 1, i_ld, MDR_OT, 16'h0020, 0, 0, B, 0);
      push("ld_idle_end", 1, 0, i_nop, 0, 0, 0, 0, 0, 1);
      push("to_t0", 1, 0, i_nop, F0, 0, 0, 0, B, 1);
      for (int k = 0; k < 15; k++)
         push("t1_last_ready", 1, (k == 14), i_nop, F1, 0, 0, 0, B, 1);
      push("t1_prio_t2", 1, 1, i_nop, F2, 0, 0, 0, B, 1);
      push("t1_prio_t3", 1, 0, i_nop, 0, 0, 0, 0, B, 1);
      push("to2_t0", 1, 0, i_nop, F0, 0, 0, 0, B, 2);
      for (int k = 0; k < 15; k++)
         push("t1_stuck", 1, 0, i_nop, F1, 0, 0, 0, B, 2);
      push("timeout_a", 1, 1, i_nop, 0, 0, 0, 0, F, 2);
      push("timeout_b", 1, 1, i_nop, 0, 0, 0, 0, F, 2);
      run_tbl();

      do_clear(1'b0);
      push("ill_idle", 1, 1, i_ill, 0, 0, 0, 0, 0, 0);
      fetch("ill", i_ill, 0);
      push("ill_t3", 1, 1, i_ill, 0, 0, 0, 0, B, 0);
      push("ill_fault", 1, 1, i_ill, 0, 0, 0, 0, F, 0);
      run_tbl();

      do_clear(1'b0);
      push("clr_idle", 1, 1, i_add, 0, 0, 0, 0, 0, 0);
      fetch("clr", i_add, 0);
      push("clr_t3", 1, 1, i_add, Y_IN, 0, 16'h0002, 0, B, 0);
      push("clr_t4", 1, 1, i_add, Z_IN, 0, 16'h0004, 0, B, 0);
      run_tbl();
      do_clear(1'b1);
      push("restart_t0", 0, 1, i_add, F0, 0, 0, 0, B, 0);
      push("restart_t1", 0, 1, i_add, F1, 0, 0, 0, B, 0);
      run_tbl();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT_MAX, default 15, meaning max cycles spent in a memory wait state before FAULT.
REQ-002 SHALL have port clock  input  1  the only clock; all state changes on the rising edge.
REQ-003 SHALL have port clear  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port run  input  1  permits starting a new instruction.
REQ-005 SHALL have port ir  input  32  current instruction: opcode ir[31:27], ra ir[26:23], rb ir[22:19], rc ir[18:15].
REQ-006 SHALL have port mem_ready  input  1  memory completed the requested read or write this cycle.
REQ-007 SHALL have ports r_in and r_out  output  16 each  one-hot register-file load and drive strobes, R0..R15.
REQ-008 SHALL have 1-bit outputs pc_in, pc_out, inc_pc, ir_in, y_in, z_in, mar_in, mdr_in, mdr_out, mdr_read, mem_write, hi_in, hi_out, lo_in, lo_out, zhigh_out and zlow_out, which are the datapath strobes of the same names.
REQ-009 SHALL have port alu_select  output  4  ALU operation code.
REQ-010 SHALL have ports halted, fault and busy  output  1 each  status flags.
REQ-011 SHALL have port instr_count  output  16  count of retired instructions.

Function
REQ-012 States SHALL be IDLE, T0, T1, T2, T3, T4, T5, T6, HALT and FAULT.
REQ-013 All strobes SHALL be a function of the state register and ir only, with no combinational path from run or mem_ready.
REQ-014 At most one of r_out, pc_out, mdr_out, hi_out, lo_out, zhigh_out and zlow_out SHALL be asserted in any cycle.
REQ-015 IDLE SHALL go to T0 when run=1 and stay in IDLE otherwise.
REQ-016 T0 SHALL assert pc_out, mar_in, inc_pc and z_in, then go to T1.
REQ-017 T1 SHALL assert zlow_out, pc_in, mdr_read and mdr_in, hold in T1 until mem_ready=1, then go to T2.
REQ-018 T2 SHALL assert mdr_out and ir_in, then go to T3.
REQ-019 The decoded opcode in T3 and later SHALL select the execute sequence; the sequence SHALL end by returning to T0 if run=1, or to IDLE if run=0.
REQ-020 add=00011, sub=00100, and=00101, or=00110: T3 r_out[rb] and y_in; T4 r_out[rc], alu_select=op and z_in; T5 zlow_out and r_in[ra].
REQ-021 mul=01111, div=10000: T3 r_out[ra] and y_in; T4 r_out[rb], alu_select=op and z_in; T5 zlow_out and lo_in; T6 zhigh_out and hi_in.
REQ-022 ld=00000: T3 r_out[rb] and mar_in; T4 mdr_read and mdr_in, held until mem_ready; T5 mdr_out and r_in[ra].
REQ-023 st=00001: T3 r_out[rb] and mar_in; T4 r_out[ra] and mdr_in; T5 mem_write, held until mem_ready.
REQ-024 mfhi=11000 SHALL execute T3 hi_out and r_in[ra]; mflo=11001 SHALL execute T3 lo_out and r_in[ra].
REQ-025 nop=11010 SHALL end in T3 with no strobes asserted.
REQ-026 halt=11011 SHALL go to HALT, where halted=1 and no strobes are asserted until clear.
REQ-027 Any other opcode SHALL go to FAULT, where fault=1 and no strobes are asserted until clear.
REQ-028 The wait counter SHALL be zeroed on entry to each wait state and increment each cycle that mem_ready=0.
REQ-029 If the wait counter reaches MEM_WAIT_MAX, the sequencer SHALL go to FAULT; mem_ready=1 in that same cycle SHALL take priority.
REQ-030 instr_count SHALL increment by 1 on each sequence end and on halt, wrap 0xFFFF to 0x0000, and not increment on FAULT.
REQ-031 busy SHALL be 1 in every state except IDLE, HALT and FAULT.
REQ-032 alu_select codes SHALL be ADD=0, SUB=1, AND=2, OR=3, MUL=4, DIV=5, and 0 when unused.

Reset
REQ-033 clear=0 SHALL force, asynchronously and from any state including mid-wait, state=IDLE, all strobes 0, alu_select=0, halted=0, fault=0, busy=0, instr_count=0 and wait counter=0.
REQ-034 After clear deasserts, the first possible T0 SHALL be the first rising edge with run=1.

Structure
REQ-035 Shared package cpu_ctrl_pkg SHALL hold the opcode constants, ALU select codes, state enum and ir field positions.
REQ-036 The wait counter and timeout compare SHALL be one sub-module, mem_wait_timer; the rest SHALL be flat.

Verification
REQ-037 add R3,R1,R2 with mem_ready=1 every cycle -> T0..T5 in 6 cycles; T5 shows r_in=0x0008 and zlow_out=1; instr_count=1.
REQ-038 ld R5,(R2) with mem_ready delayed 3 cycles in T4 -> strobes held stable 4 cycles, then T5 shows r_in=0x0020 and mdr_out=1.
REQ-039 mem_ready stuck at 0 in T1 with MEM_WAIT_MAX=15 -> fault=1 after 15 cycles; strobes 0; instr_count unchanged.
REQ-040 mul R4,R6 -> T5 shows lo_in=1 and zlow_out=1; T6 shows hi_in=1 and zhigh_out=1; alu_select=4 in T4.
REQ-041 Opcode 10101 -> fault=1; halt -> halted=1 and busy=0; run=0 at a sequence end -> IDLE.
REQ-042 clear pulsed low mid-T4 -> all outputs 0 immediately; restart from T0 when run=1; one-hot bus-drive invariant checked every cycle.
